pool1_ctrl: RTL and testbench

//  Sequencer for the pool1 stage. Reads the six 28x28 C1 feature maps (f2_1..f2_6, shared address)
//  in 2x2 window order and drives pool1_clr to the six pool_unit datapaths. Writes each pooled

---
 rtl/pool1_ctrl.sv | 179 +++++++++++++++++
 tb/tb_pool1_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pool1_ctrl.sv
// rtl/pool1_ctrl.sv - pool1 stage sequencer: 2x2 window reads from f2 maps, pooled writes to f3 maps
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   pool1_start  in   one-cycle start pulse, accepted only when idle
//   pool1_busy   out  high from the first cycle after an accepted start through the done cycle
//   pool1_done   out  one-cycle pulse after the final f3 write
//   f2_rd_en     out  read strobe shared by the six f2 RAMs
//   f2_raddr     out  f2 element address (row*IN_W+col), held while f2_rd_en is low
//   pool1_clr    out  high in the cycle the first element of a window is on the f2 read data
//   f3_wr_en     out  write strobe shared by the six f3 RAMs
//   f3_waddr     out  f3 window address (orow*OUT_W+ocol), held while f3_wr_en is low
module pool1_ctrl #(
  parameter int IN_W   = 28,
  parameter int OUT_W  = 14,
  parameter int RAW    = 10,
  parameter int WAW    = 8,
  parameter int RD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           pool1_start,
  output logic           pool1_busy,
  output logic           pool1_done,
  output logic           f2_rd_en,
  output logic [RAW-1:0] f2_raddr,
  output logic           pool1_clr,
  output logic           f3_wr_en,
  output logic [WAW-1:0] f3_waddr
);

  localparam logic [WAW-1:0] LAST_WIN   = WAW'(OUT_W*OUT_W-1);
  localparam logic [WAW-1:0] LAST_COL   = WAW'(OUT_W-1);
  localparam logic [RAW-1:0] ROW_OFF    = RAW'(IN_W);
  localparam logic [RAW-1:0] COL_STEP   = RAW'(2);
  localparam logic [RAW-1:0] ROW_STEP   = RAW'(IN_W+2);
  localparam logic [1:0]     DRAIN_LAST = 2'(RD_LAT);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e         state_q;
  logic           busy_q;
  logic           done_q;
  logic           rd_en_q;
  logic [RAW-1:0] raddr_q;
  logic [1:0]     dcnt_q;

  // Position of the next read to issue.
  logic [1:0]     nk_q;
  logic [RAW-1:0] base_q;
  logic [WAW-1:0] ocol_q;
  logic [WAW-1:0] win_q;

  // Element index and window of the read currently on the bus.
  logic [1:0]     k_q;
  logic [WAW-1:0] wtag_q;

  logic [RAW-1:0] raddr_d;
  logic           last_rd;

  // Window element offsets +0, +1, +IN_W, +IN_W+1 picked from the two bits of nk_q.
  assign raddr_d = base_q + (nk_q[1] ? ROW_OFF : '0) + RAW'(nk_q[0]);
  assign last_rd = (k_q == 2'd3) && (wtag_q == LAST_WIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      raddr_q <= '0;
      dcnt_q  <= '0;
      nk_q    <= '0;
      base_q  <= '0;
      ocol_q  <= '0;
      win_q   <= '0;
      k_q     <= '0;
      wtag_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pool1_start) begin
            // Element 0 of window 0 goes out in the first busy cycle; counters restart here.
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            rd_en_q <= 1'b1;
            raddr_q <= '0;
            k_q     <= 2'd0;
            wtag_q  <= '0;
            nk_q    <= 2'd1;
            base_q  <= '0;
            ocol_q  <= '0;
            win_q   <= '0;
          end
        end
        S_RUN: begin
          if (last_rd) begin
            state_q <= S_DRAIN;
            rd_en_q <= 1'b0;
            dcnt_q  <= '0;
          end else begin
            raddr_q <= raddr_d;
            k_q     <= nk_q;
            wtag_q  <= win_q;
            nk_q    <= nk_q + 2'd1;
            if (nk_q == 2'd3) begin
              win_q <= win_q + WAW'(1);
              if (ocol_q == LAST_COL) begin
                ocol_q <= '0;
                base_q <= base_q + ROW_STEP;
              end else begin
                ocol_q <= ocol_q + WAW'(1);
                base_q <= base_q + COL_STEP;
              end
            end
          end
        end
        S_DRAIN: begin
          if (dcnt_q == DRAIN_LAST) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            dcnt_q <= dcnt_q + 2'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Control delay line: stage i holds the read issued i+1 cycles earlier.
  logic           clr_p_q [RD_LAT];
  logic           wr_p_q  [RD_LAT+1];
  logic [WAW-1:0] wa_p_q  [RD_LAT];
  logic [WAW-1:0] waddr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        clr_p_q[i] <= 1'b0;
        wa_p_q[i]  <= '0;
      end
      for (int i = 0; i <= RD_LAT; i++) begin
        wr_p_q[i] <= 1'b0;
      end
      waddr_q <= '0;
    end else begin
      clr_p_q[0] <= rd_en_q && (k_q == 2'd0);
      wr_p_q[0]  <= rd_en_q && (k_q == 2'd3);
      wa_p_q[0]  <= wtag_q;
      for (int i = 1; i < RD_LAT; i++) begin
        clr_p_q[i] <= clr_p_q[i-1];
        wa_p_q[i]  <= wa_p_q[i-1];
      end
      for (int i = 1; i <= RD_LAT; i++) begin
        wr_p_q[i] <= wr_p_q[i-1];
      end
      // Load the write address one stage early so it lines up with the strobe and then holds.
      if (wr_p_q[RD_LAT-1]) begin
        waddr_q <= wa_p_q[RD_LAT-1];
      end
    end
  end

  assign pool1_busy = busy_q;
  assign pool1_done = done_q;
  assign f2_rd_en   = rd_en_q;
  assign f2_raddr   = raddr_q;
  assign pool1_clr  = clr_p_q[RD_LAT-1];
  assign f3_wr_en   = wr_p_q[RD_LAT];
  assign f3_waddr   = waddr_q;

endmodule

// File: tb/tb_pool1_ctrl.sv
// tb/tb_pool1_ctrl.sv - scoreboard bench for pool1_ctrl with RD_LAT=1 and RD_LAT=2 instances
module tb_pool1_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       start_s [2];
  logic       rstn_s  [2];
  logic       busy_s  [2];
  logic       done_s  [2];
  logic       rd_en_s [2];
  logic       clr_s   [2];
  logic       wr_s    [2];
  logic [9:0] raddr_s [2];
  logic [7:0] waddr_s [2];

  int t0 [2] = '{-100000, -100000};
  int n_pass = 0;
  int n_tot  = 0;
  int q0 [$];
  int q1 [$];

  int seq_cyc  [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 57, 58, 59, 60};
  int seq_addr [12] = '{0, 1, 28, 29, 2, 3, 30, 31, 56, 57, 84, 85};

  task automatic chk(string nm, int act, int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic void q_push(int d, int v);
    if (d == 0) q0.push_back(v);
    else q1.push_back(v);
  endfunction

  function automatic int q_pop(int d);
    if (d == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  function automatic int q_size(int d);
    if (d == 0) return q0.size();
    return q1.size();
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = g + 1;
    logic [9:0] rd1 = '0;
    logic [9:0] rd2 = '0;
    logic [9:0] rdata;
    logic [9:0] d_out = '0;
    int n_rd, n_clr, n_wr, n_done, n_busy, n_spot;
    int first_clr, first_wr, last_wr, done_cyc, first_busy, last_busy;
    int ra_log [800];
    int wa_log [800];

    pool1_ctrl #(.RD_LAT(LAT)) u_dut (
      .clk         (clk),
      .rst_n       (rstn_s[g]),
      .pool1_start (start_s[g]),
      .pool1_busy  (busy_s[g]),
      .pool1_done  (done_s[g]),
      .f2_rd_en    (rd_en_s[g]),
      .f2_raddr    (raddr_s[g]),
      .pool1_clr   (clr_s[g]),
      .f3_wr_en    (wr_s[g]),
      .f3_waddr    (waddr_s[g])
    );

    // f2 RAM with mem[a]=a and the pool unit max/clear datapath.
    always @(posedge clk) begin
      if (rd_en_s[g]) rd1 <= raddr_s[g];
      rd2 <= rd1;
      if (clr_s[g]) d_out <= rdata;
      else if (rdata > d_out) d_out <= rdata;
    end
    assign rdata = (LAT == 1) ? rd1 : rd2;

    always @(negedge clk) begin : mon
      int rel;
      int e;
      rel = cyc - t0[g];
      if (rel == 0) begin
        n_rd = 0; n_clr = 0; n_wr = 0; n_done = 0; n_busy = 0; n_spot = 0;
        first_clr = -1; first_wr = -1; last_wr = -1; done_cyc = -1;
        first_busy = -1; last_busy = -1;
      end
      if (rel >= 0 && rel < 800) begin
        ra_log[rel] = int'(raddr_s[g]);
        wa_log[rel] = int'(waddr_s[g]);
      end
      if (rd_en_s[g]) n_rd++;
      if (clr_s[g]) begin
        n_clr++;
        if (first_clr < 0) first_clr = rel;
      end
      if (busy_s[g]) begin
        n_busy++;
        if (first_busy < 0) first_busy = rel;
        last_busy = rel;
      end
      if (done_s[g]) begin
        n_done++;
        done_cyc = rel;
      end
      if (wr_s[g]) begin
        n_wr++;
        if (first_wr < 0) first_wr = rel;
        last_wr = rel;
        if (q_size(g) == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          e = q_pop(g);
          chk("sb_waddr", int'(waddr_s[g]), e >> 16);
          chk("sb_wdata", int'(d_out), e & 32'hffff);
        end
        case (waddr_s[g])
          8'd0:    begin chk("f3_0", int'(d_out), 29);    n_spot++; end
          8'd13:   begin chk("f3_13", int'(d_out), 55);   n_spot++; end
          8'd14:   begin chk("f3_14", int'(d_out), 85);   n_spot++; end
          8'd195:  begin chk("f3_195", int'(d_out), 783); n_spot++; end
          default: ;
        endcase
      end
      if (rel == 787 + LAT) begin
        chk("n_rd_en", n_rd, 784);
        chk("n_clr", n_clr, 196);
        chk("n_wr_en", n_wr, 196);
        chk("n_done", n_done, 1);
        chk("first_clr", first_clr, LAT + 1);
        chk("first_wr", first_wr, LAT + 5);
        chk("last_wr", last_wr, 785 + LAT);
        chk("done_cycle", done_cyc, 786 + LAT);
        chk("first_busy", first_busy, 1);
        chk("last_busy", last_busy, 786 + LAT);
        chk("n_busy", n_busy, 786 + LAT);
        chk("sb_empty", q_size(g), 0);
        chk("n_spot", n_spot, 4);
        chk("raddr_hold", ra_log[786], 783);
        chk("waddr_hold", wa_log[787 + LAT], 195);
        for (int i = 0; i < 12; i++) chk("raddr_seq", ra_log[seq_cyc[i]], seq_addr[i]);
      end
    end
  end

  task automatic begin_run(int d);
    t0[d] = cyc;
    for (int w = 0; w < 196; w++)
      q_push(d, (w << 16) | ((2 * (w / 14) + 1) * 28 + 2 * (w % 14) + 1));
    start_s[d] = 1'b1;
  endtask

  task automatic idle_cycles(int d, int n);
    for (int c = 1; c <= n; c++) begin
      @(posedge clk);
      #1;
      start_s[d] = 1'b0;
    end
  endtask

  task automatic chk_quiet(int d, string tag);
    chk({tag, "_busy"}, int'(busy_s[d]), 0);
    chk({tag, "_done"}, int'(done_s[d]), 0);
    chk({tag, "_rd_en"}, int'(rd_en_s[d]), 0);
    chk({tag, "_raddr"}, int'(raddr_s[d]), 0);
    chk({tag, "_clr"}, int'(clr_s[d]), 0);
    chk({tag, "_wr_en"}, int'(wr_s[d]), 0);
    chk({tag, "_waddr"}, int'(waddr_s[d]), 0);
  endtask

  initial begin
    start_s[0] = 1'b0; start_s[1] = 1'b0;
    rstn_s[0]  = 1'b0; rstn_s[1]  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start_s[0] = 1'b1; start_s[1] = 1'b1;
    @(posedge clk);
    #1;
    start_s[0] = 1'b0; start_s[1] = 1'b0;
    @(posedge clk);
    #1;
    chk_quiet(0, "rst_hold0");
    chk_quiet(1, "rst_hold1");
    rstn_s[0] = 1'b1; rstn_s[1] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_busy0", int'(busy_s[0]), 0);
    chk("idle_busy1", int'(busy_s[1]), 0);

    // Ramp run with ignored starts at 100 and 787, then a second pass started at 790.
    begin_run(0);
    for (int c = 1; c <= 790; c++) begin
      @(posedge clk);
      #1;
      start_s[0] = (c == 100 || c == 787);
      if (c == 789) chk("ignored_start_busy", int'(busy_s[0]), 0);
    end
    begin_run(0);
    idle_cycles(0, 795);

    // Abort at cycle 400, then a clean run.
    begin_run(0);
    idle_cycles(0, 400);
    #2;
    rstn_s[0] = 1'b0;
    #1;
    chk_quiet(0, "abort");
    q0.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", g_dut[0].n_done, 0);
    rstn_s[0] = 1'b1;
    @(posedge clk);
    #1;
    begin_run(0);
    idle_cycles(0, 795);

    // RD_LAT=2 instance.
    begin_run(1);
    idle_cycles(1, 795);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
